// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types for the seven-segment scan driver: segment bit order,
// hex-to-segment table and the scan FSM state encoding.
package seven_seg_scan_driver_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // Active-high {g,f,e,d,c,b,a}; b and d use the lower-case glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_decoder.sv
// Combinational hex nibble plus decimal point to active-high segment pattern.
// Output polarity is handled by the parent at its output register.
module seven_seg_decoder
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Pattern lookup with the decimal point on the top bit.
    always_comb begin
        seg_o          = 8'h00;
        seg_o[6:0]     = hex_to_seg(nibble_i);
        seg_o[SEG_DP]  = dp_i;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display scanner with per-slot guard blanking and a
// double-buffered display word that only changes on frame boundaries.
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int SCAN_DIV        = 1024,
    parameter int BLANK_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW  = 1'b0,
    parameter bit GATE_ACTIVE_LOW = 1'b0
) (
    input  logic                    clkBase,
    input  logic                    rst,
    input  logic                    dispLoad,
    input  logic [4*NUM_DIGITS-1:0] dispData,
    input  logic [NUM_DIGITS-1:0]   dispDp,
    input  logic [NUM_DIGITS-1:0]   dispBlank,
    output logic [7:0]              led,
    output logic [NUM_DIGITS-1:0]   gate,
    output logic                    frameDone
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      SHOW_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
    localparam logic [7:0]            LED_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] GATE_OFF  = GATE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] GATE_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d;
    logic                    pending_q, pending_d;

    logic [7:0]              led_q, led_d;
    logic [NUM_DIGITS-1:0]   gate_q, gate_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic [3:0]              cur_nibble_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;
    logic [7:0]              cur_seg_s;

    // Slot and frame boundary detection from the current scan position.
    always_comb begin
        slot_end_s = (cnt_q == SLOT_LAST);
        wrap_s     = slot_end_s && (idx_q == IDX_LAST);
    end

    // Select the active-buffer fields for the digit being scanned.
    always_comb begin
        cur_nibble_s = act_data_q[{idx_q, 2'b00} +: 4];
        cur_dp_s     = act_dp_q[idx_q];
        cur_blank_s  = act_blank_q[idx_q];
    end

    seven_seg_decoder u_decoder (
        .nibble_i (cur_nibble_s),
        .dp_i     (cur_dp_s),
        .seg_o    (cur_seg_s)
    );

    // Scan FSM: SHOW then BLANK within each slot; slot end always wins so a
    // zero-length blank interval skips straight to the next digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        if (slot_end_s) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (wrap_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
                ST_BLANK: begin
                    state_d = ST_BLANK;
                end
                default: begin
                    state_d = ST_SHOW;
                end
            endcase
        end
    end

    // Display buffers: a load on the frame wrap bypasses the shadow.
    always_comb begin
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        shd_data_d  = shd_data_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        pending_d   = pending_q;
        if (wrap_s && dispLoad) begin
            act_data_d  = dispData;
            act_dp_d    = dispDp;
            act_blank_d = dispBlank;
            shd_data_d  = dispData;
            shd_dp_d    = dispDp;
            shd_blank_d = dispBlank;
            pending_d   = 1'b0;
        end else if (wrap_s && pending_q) begin
            act_data_d  = shd_data_q;
            act_dp_d    = shd_dp_q;
            act_blank_d = shd_blank_q;
            pending_d   = 1'b0;
        end else if (dispLoad) begin
            shd_data_d  = dispData;
            shd_dp_d    = dispDp;
            shd_blank_d = dispBlank;
            pending_d   = 1'b1;
        end else begin
            pending_d   = pending_q;
        end
    end

    // Output pattern for the current scan position, polarity applied here.
    always_comb begin
        led_d        = LED_OFF;
        gate_d       = GATE_OFF;
        frame_done_d = wrap_s;
        if ((state_q == ST_SHOW) && !cur_blank_s) begin
            led_d  = cur_seg_s ^ LED_OFF;
            gate_d = (GATE_ONE << idx_q) ^ GATE_OFF;
        end else begin
            led_d  = LED_OFF;
            gate_d = GATE_OFF;
        end
    end

    // State, buffer and output registers; rst overrides any concurrent load.
    always_ff @(posedge clkBase) begin
        if (rst) begin
            state_q      <= ST_SHOW;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= {NUM_DIGITS{1'b1}};
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
            pending_q    <= 1'b0;
            led_q        <= LED_OFF;
            gate_q       <= GATE_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            shd_data_q   <= shd_data_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            pending_q    <= pending_d;
            led_q        <= led_d;
            gate_q       <= gate_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led       = led_q;
    assign gate      = gate_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed plus randomized bench for seven_seg_scan_driver, checked against a
// cycle-count reference model of the scan, blanking and frame-commit rules.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic        clk;
    logic        rst;
    logic        dispLoad;
    logic [15:0] dispData;
    logic [3:0]  dispDp;
    logic [3:0]  dispBlank;
    logic [7:0]  led;
    logic [3:0]  gate;
    logic        frameDone;

    int checks = 0;
    int errors = 0;

    int          k;
    logic [15:0] m_act_data, m_shd_data;
    logic [3:0]  m_act_dp, m_shd_dp, m_act_blank, m_shd_blank;
    logic        m_pend;

    int   n_fd, n_one, n_two, n_f, n_other, n_lit;
    logic [3:0] gate_or;

    seven_seg_scan_driver #(
        .NUM_DIGITS      (ND),
        .SCAN_DIV        (SD),
        .BLANK_CYCLES    (BC),
        .SEG_ACTIVE_LOW  (1'b0),
        .GATE_ACTIVE_LOW (1'b0)
    ) dut (
        .clkBase   (clk),
        .rst       (rst),
        .dispLoad  (dispLoad),
        .dispData  (dispData),
        .dispDp    (dispDp),
        .dispBlank (dispBlank),
        .led       (led),
        .gate      (gate),
        .frameDone (frameDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by one cycle, check outputs.
    task automatic tick(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] p, input logic [3:0] b);
        int pos;
        int dig;
        logic [7:0] e_led;
        logic [3:0] e_gate;
        logic       e_fd;
        rst = r; dispLoad = ld; dispData = d; dispDp = p; dispBlank = b;
        @(posedge clk);
        e_led = 8'h00; e_gate = 4'h0; e_fd = 1'b0;
        if (r) begin
            m_act_data = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'hF;
            m_shd_data = 16'h0; m_shd_dp = 4'h0; m_shd_blank = 4'h0;
            m_pend = 1'b0;
            k = 0;
        end else begin
            pos = k % SD;
            dig = (k / SD) % ND;
            if (pos < SD - BC && !m_act_blank[dig]) begin
                e_gate = 4'b0001 << dig;
                e_led  = {m_act_dp[dig], glyph(m_act_data[dig*4 +: 4])};
            end
            e_fd = ((k % FRAME) == FRAME - 1);
            if (e_fd) begin
                if (ld) begin
                    m_act_data = d; m_act_dp = p; m_act_blank = b;
                end else if (m_pend) begin
                    m_act_data = m_shd_data; m_act_dp = m_shd_dp; m_act_blank = m_shd_blank;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_shd_data = d; m_shd_dp = p; m_shd_blank = b;
                m_pend = 1'b1;
            end
            k++;
        end
        #1;
        check("led", {24'h0, led}, {24'h0, e_led});
        check("gate", {28'h0, gate}, {28'h0, e_gate});
        check("frameDone", {31'h0, frameDone}, {31'h0, e_fd});
        if (frameDone) n_fd++;
        gate_or = gate_or | gate;
        if (gate != 4'h0) begin
            n_lit++;
            if (led[6:0] == 7'h06) n_one++;
            if (led[6:0] == 7'h5B) n_two++;
            if (led[6:0] == 7'h71) n_f++; else n_other++;
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    endtask

    task automatic clear_stats();
        n_fd = 0; n_one = 0; n_two = 0; n_f = 0; n_other = 0; n_lit = 0;
        gate_or = 4'h0;
    endtask

    initial begin
        logic [7:0] exp_seg [4];
        logic       r_r;
        logic       r_ld;
        exp_seg[0] = 8'h3F; exp_seg[1] = 8'h07; exp_seg[2] = 8'hF7; exp_seg[3] = 8'h4F;
        rst = 1'b1; dispLoad = 1'b0; dispData = 16'h0; dispDp = 4'h0; dispBlank = 4'h0;
        k = 0; m_pend = 1'b0;
        m_act_data = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'hF;
        m_shd_data = 16'h0; m_shd_dp = 4'h0; m_shd_blank = 4'h0;
        clear_stats();

        // Reset, then two dark frames.
        repeat (3) tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        clear_stats();
        repeat (64) idle();
        check("idle_frame_done_count", n_fd, 2);
        check("idle_gate_dark", {28'h0, gate_or}, 32'h0);

        // Mid-frame load only appears after the next frame boundary.
        repeat (10) idle();
        clear_stats();
        tick(1'b0, 1'b1, 16'h3A70, 4'b0100, 4'b0000);
        while (k % FRAME != 0) idle();
        check("no_early_commit", {28'h0, gate_or}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("digit_led", {24'h0, led}, {24'h0, exp_seg[i]});
            check("digit_gate", {28'h0, gate}, 32'h1 << i);
            repeat (5) idle();
            idle();
            check("guard_gate", {28'h0, gate}, 32'h0);
            idle();
        end

        // Two loads in one frame: last wins.
        clear_stats();
        repeat (3) idle();
        tick(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0);
        repeat (5) idle();
        tick(1'b0, 1'b1, 16'h2222, 4'h0, 4'h0);
        repeat (64) idle();
        check("first_load_never_shown", n_one, 0);
        check("last_load_shown", {31'h0, n_two > 0}, 32'h1);

        // Load on the commit cycle goes straight to active and clears pending.
        repeat (2) idle();
        tick(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
        while (k % FRAME != FRAME - 1) idle();
        tick(1'b0, 1'b1, 16'hFFFF, 4'h0, 4'h0);
        clear_stats();
        repeat (64) idle();
        check("commit_cycle_F_count", n_f, 48);
        check("commit_cycle_no_stale", n_other, 0);

        // Blanked digits keep slot timing.
        tick(1'b0, 1'b1, 16'h8888, 4'b1010, 4'b0101);
        while (k % FRAME != 0) idle();
        clear_stats();
        repeat (64) idle();
        check("blanked_gates_dark", {28'h0, gate_or & 4'b0101}, 32'h0);
        check("blank_frame_done_count", n_fd, 2);
        check("blank_lit_cycles", n_lit, 24);

        // Reset mid-SHOW of digit 2 with a load pending.
        repeat (3) idle();
        tick(1'b0, 1'b1, 16'h5555, 4'h0, 4'h0);
        while (k % FRAME != 2 * SD + 2) idle();
        tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        check("rst_led_off", {24'h0, led}, 32'h0);
        check("rst_gate_off", {28'h0, gate}, 32'h0);
        clear_stats();
        repeat (64) idle();
        check("pending_discarded", n_lit, 0);
        check("restart_frame_done_count", n_fd, 2);

        // Randomized traffic, with extra weight on commit-cycle loads.
        repeat (800) begin
            r_r  = ($urandom_range(0, 299) == 0);
            r_ld = ($urandom_range(0, 15) == 0);
            if ((k % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 0)) r_ld = 1'b1;
            tick(r_r, r_ld, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
